// File: rtl/imm_pkg.sv
// Shared types and LEGv8 opcode prefixes for the pipelined immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_B    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5
    } imm_fmt_t;

    // Prefixes compared against instr[31:(32-width)]
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [9:0]  OP_SUBI = 10'h344;
    localparam logic [8:0]  OP_MOVZ = 9'h1A5;
    localparam logic [8:0]  OP_MOVK = 9'h1E5;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [7:0]  OP_CBNZ = 8'hB5;
    localparam logic [5:0]  OP_B    = 6'b000101;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction in, extended immediate out.
interface imm_gen_pipe_if #(parameter int N = 64);
    import imm_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_instr;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_imm;
    imm_fmt_t       out_fmt;
    logic           out_illegal;

    // master drives instructions and consumes results; slave is the generator
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational LEGv8 immediate decode to N bits. IW (MOVZ/MOVK) decode and its
// shifter exist only when IMM_GEN_IW_EN is defined; otherwise those opcodes are illegal.
module imm_decode
    import imm_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [31:0]  instr_i,
    output logic [N-1:0] imm_o,
    output imm_fmt_t     fmt_o,
    output logic         illegal_o
);

    generate
        if (N < 32) begin : g_bad_width
            $error("imm_decode: N must be at least 32");
        end
    endgenerate

    // Longest prefix first so wider opcodes win over shorter ones
    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        if (instr_i[31:21] == OP_LDUR || instr_i[31:21] == OP_STUR) begin
            imm_o = {{(N-9){instr_i[20]}}, instr_i[20:12]};
            fmt_o = FMT_D;
        end else if (instr_i[31:22] == OP_ADDI || instr_i[31:22] == OP_SUBI) begin
            imm_o = {{(N-12){1'b0}}, instr_i[21:10]};
            fmt_o = FMT_I;
`ifdef IMM_GEN_IW_EN
        end else if (instr_i[31:23] == OP_MOVZ || instr_i[31:23] == OP_MOVK) begin
            imm_o = {{(N-16){1'b0}}, instr_i[20:5]} << {instr_i[22:21], 4'b0000};
            fmt_o = FMT_IW;
`endif
        end else if (instr_i[31:24] == OP_CBZ || instr_i[31:24] == OP_CBNZ) begin
            imm_o = {{(N-19){instr_i[23]}}, instr_i[23:5]};
            fmt_o = FMT_CB;
        end else if (instr_i[31:26] == OP_B) begin
            imm_o = {{(N-26){instr_i[25]}}, instr_i[25:0]};
            fmt_o = FMT_B;
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Valid/ready front end for imm_decode: one output register plus one skid entry,
// strict FIFO order, synchronous flush, asynchronous active-low reset.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int N = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    imm_gen_pipe_if.slave   bus
);

    logic [N-1:0] dec_imm;
    imm_fmt_t     dec_fmt;
    logic         dec_ill;

    logic         main_valid_q, main_valid_d;
    logic [N-1:0] main_imm_q,   main_imm_d;
    imm_fmt_t     main_fmt_q,   main_fmt_d;
    logic         main_ill_q,   main_ill_d;
    logic         skid_valid_q, skid_valid_d;
    logic [N-1:0] skid_imm_q,   skid_imm_d;
    imm_fmt_t     skid_fmt_q,   skid_fmt_d;
    logic         skid_ill_q,   skid_ill_d;

    logic accept;
    logic drain;

    imm_decode #(.N(N)) u_decode (
        .instr_i   (bus.in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_ill)
    );

    assign accept = bus.in_valid && !skid_valid_q;
    assign drain  = main_valid_q && bus.out_ready;

    // Accept is impossible while the skid entry is full, so the refill path never loses input
    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_fmt_d   = main_fmt_q;
        main_ill_d   = main_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_ill_d   = skid_ill_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_fmt_d   = skid_fmt_q;
                main_ill_d   = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_imm_d   = dec_imm;
                main_fmt_d   = dec_fmt;
                main_ill_d   = dec_ill;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
            skid_ill_d   = dec_ill;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_fmt_q   <= FMT_NONE;
            main_ill_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
            skid_ill_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_fmt_q   <= main_fmt_d;
            main_ill_q   <= main_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign bus.in_ready    = !skid_valid_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_imm     = main_imm_q;
    assign bus.out_fmt     = main_fmt_q;
    assign bus.out_illegal = main_ill_q;

endmodule
